// File: rtl/uart_rx_msg_assembler_if.sv
// Byte-stream input and assembled-message output bundle of the UART RX message assembler.
// The slave modport is the assembler, the master modport is whatever drives it.
interface uart_rx_msg_assembler_if #(
   parameter int N     = 8,
   parameter int M     = 128,
   parameter int CNT_W = 5
);
   logic             rx_valid;
   logic [N-1:0]     rx_data;
   logic             rx_ferr;
   logic             msg_ack;
   logic [M-1:0]     data;
   logic             msg_valid;
   logic [CNT_W-1:0] byte_cnt;
   logic [1:0]       state;
   logic             overrun;
   logic             frame_err;
   logic             timeout;

   modport slave (
      input  rx_valid, rx_data, rx_ferr, msg_ack,
      output data, msg_valid, byte_cnt, state, overrun, frame_err, timeout
   );

   modport master (
      output rx_valid, rx_data, rx_ferr, msg_ack,
      input  data, msg_valid, byte_cnt, state, overrun, frame_err, timeout
   );
endinterface

// File: rtl/uart_rx_msg_assembler.sv
// Packs UART RX bytes MSB-first into an M-bit message held behind a valid/ack buffer,
// resynchronising message boundaries on framing errors and inter-byte timeouts.
module uart_rx_msg_assembler #(
   parameter int N       = 8,
   parameter int M       = 128,
   parameter int CNT_W   = 5,
   parameter int TIMEOUT = 200000,
   parameter int TW      = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_rx_msg_assembler_if.slave bus
);
   localparam int BYTES = M / N;
   localparam int SH_W  = M - N;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1
   } state_e;

   state_e           state_q, state_d;
   logic [SH_W-1:0]  sh_q, sh_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [M-1:0]     data_q, data_d;
   logic             msg_valid_q, msg_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             timeout_q, timeout_d;

   logic accept, ferr, last, buf_free;

   assign accept   = bus.rx_valid & ~bus.rx_ferr;
   assign ferr     = bus.rx_valid & bus.rx_ferr;
   assign last     = accept && (byte_cnt_q == CNT_W'(BYTES - 1));
   assign buf_free = ~msg_valid_q | bus.msg_ack;

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      byte_cnt_d  = byte_cnt_q;
      timer_d     = timer_q;
      data_d      = data_q;
      msg_valid_d = msg_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;

      // A load on this same edge below overrides the clear.
      if (msg_valid_q && bus.msg_ack) msg_valid_d = 1'b0;

      if (state_q != IDLE && state_q != COLLECT) begin
         state_d    = IDLE;
         byte_cnt_d = '0;
         timer_d    = '0;
      end else if (ferr) begin
         frame_err_d = 1'b1;
         byte_cnt_d  = '0;
         timer_d     = '0;
         state_d     = IDLE;
      end else if (accept) begin
         sh_d    = SH_W'({sh_q, bus.rx_data});
         timer_d = '0;
         if (last) begin
            byte_cnt_d = '0;
            state_d    = IDLE;
            if (buf_free) begin
               data_d      = {sh_q, bus.rx_data};
               msg_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            state_d    = COLLECT;
         end
      end else if (state_q == COLLECT) begin
         if (timer_q == TW'(TIMEOUT - 1)) begin
            byte_cnt_d = '0;
            timer_d    = '0;
            state_d    = IDLE;
            timeout_d  = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end else begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         byte_cnt_q  <= '0;
         timer_q     <= '0;
         data_q      <= '0;
         msg_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         byte_cnt_q  <= byte_cnt_d;
         timer_q     <= timer_d;
         data_q      <= data_d;
         msg_valid_q <= msg_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.msg_valid = msg_valid_q;
   assign bus.byte_cnt  = byte_cnt_q;
   assign bus.state     = state_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_uart_rx_msg_assembler.sv
// Bench for uart_rx_msg_assembler: vector table, directed corner sequences and a random
// phase, all checked against a queue-based message model.
module tb_uart_rx_msg_assembler;
   localparam int TO = 50;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   uart_rx_msg_assembler_if #(.N(8), .M(128), .CNT_W(5)) bus ();

   uart_rx_msg_assembler #(
      .N(8), .M(128), .CNT_W(5), .TIMEOUT(TO), .TW(18)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Model: the partial message is a queue of bytes, the timer counts idle clocks.
   logic [7:0]   m_part[$];
   int           m_idle;
   logic [127:0] m_data;
   bit           m_mv, m_ov, m_fe, m_to;

   task automatic model_reset();
      m_part.delete();
      m_idle = 0;
      m_data = '0;
      m_mv = 0; m_ov = 0; m_fe = 0; m_to = 0;
   endtask

   task automatic model_step();
      bit free;
      free = !m_mv || bus.msg_ack;
      m_fe = 0;
      m_to = 0;
      if (m_mv && bus.msg_ack) m_mv = 0;
      if (bus.rx_valid && bus.rx_ferr) begin
         m_part.delete();
         m_idle = 0;
         m_fe = 1;
      end else if (bus.rx_valid) begin
         m_part.push_back(bus.rx_data);
         m_idle = 0;
         if (m_part.size() == 16) begin
            if (free) begin
               m_data = '0;
               foreach (m_part[k]) m_data = {m_data[119:0], m_part[k]};
               m_mv = 1;
            end else begin
               m_ov = 1;
            end
            m_part.delete();
         end
      end else if (m_part.size() > 0) begin
         m_idle++;
         if (m_idle == TO) begin
            m_part.delete();
            m_idle = 0;
            m_to = 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check_model();
      check("m.data", bus.data, m_data);
      check("m.msg_valid", 128'(bus.msg_valid), 128'(m_mv));
      check("m.byte_cnt", 128'(bus.byte_cnt), 128'(m_part.size()));
      check("m.state", 128'(bus.state), (m_part.size() > 0) ? 128'd1 : 128'd0);
      check("m.overrun", 128'(bus.overrun), 128'(m_ov));
      check("m.frame_err", 128'(bus.frame_err), 128'(m_fe));
      check("m.timeout", 128'(bus.timeout), 128'(m_to));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit f, input bit a);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      bus.rx_ferr  = f;
      bus.msg_ack  = a;
      tick();
      bus.rx_valid = 1'b0;
      bus.rx_ferr  = 1'b0;
      bus.msg_ack  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ack_once();
      bus.msg_ack = 1'b1;
      tick();
      bus.msg_ack = 1'b0;
   endtask

   task automatic send_msg(input logic [127:0] msg, input bit ack_last);
      for (int i = 0; i < 16; i++) send_byte(msg[127-8*i -: 8], 1'b0, ack_last && (i == 15));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".data"}, bus.data, 128'd0);
      check({tag, ".msg_valid"}, 128'(bus.msg_valid), 128'd0);
      check({tag, ".byte_cnt"}, 128'(bus.byte_cnt), 128'd0);
      check({tag, ".state"}, 128'(bus.state), 128'd0);
      check({tag, ".overrun"}, 128'(bus.overrun), 128'd0);
      check({tag, ".frame_err"}, 128'(bus.frame_err), 128'd0);
      check({tag, ".timeout"}, 128'(bus.timeout), 128'd0);
   endtask

   function automatic logic [127:0] rand_msg();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   typedef struct {
      logic       rv;
      logic [7:0] rd;
      logic       rf;
      logic       ack;
      logic [4:0] cnt;
      logic       mv;
      logic       fe;
   } vec_t;

   vec_t  tbl[34];
   string hello = "Hello, Arty A7!\n";

   initial begin
      logic [127:0] ma, mb;
      int quiet;

      // Vectors: 16 bytes with a gap after each, an ack, then a framing-error byte.
      for (int i = 0; i < 16; i++) begin
         tbl[2*i]   = '{1'b1, hello[i], 1'b0, 1'b0, 5'((i + 1) % 16), (i == 15), 1'b0};
         tbl[2*i+1] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'((i + 1) % 16), (i == 15), 1'b0};
      end
      tbl[32] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
      tbl[33] = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_ferr  = 1'b0;
      bus.msg_ack  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 34; i++) begin
         bus.rx_valid = tbl[i].rv;
         bus.rx_data  = tbl[i].rd;
         bus.rx_ferr  = tbl[i].rf;
         bus.msg_ack  = tbl[i].ack;
         tick();
         check($sformatf("vec%0d.byte_cnt", i), 128'(bus.byte_cnt), 128'(tbl[i].cnt));
         check($sformatf("vec%0d.msg_valid", i), 128'(bus.msg_valid), 128'(tbl[i].mv));
         check($sformatf("vec%0d.frame_err", i), 128'(bus.frame_err), 128'(tbl[i].fe));
         if (i == 30) check("hello.data", bus.data, 128'h48656C6C6F2C2041727479204137210A);
      end
      bus.rx_valid = 1'b0; bus.rx_ferr = 1'b0; bus.msg_ack = 1'b0;
      tick();
      check("fe.pulse_end", 128'(bus.frame_err), 128'd0);

      // Timeout: 5 bytes then silence.
      for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 1; i < TO; i++) begin
         tick();
         check("to.cnt_hold", 128'(bus.byte_cnt), 128'd5);
         check("to.early", 128'(bus.timeout), 128'd0);
      end
      tick();
      check("to.pulse", 128'(bus.timeout), 128'd1);
      check("to.cnt_clear", 128'(bus.byte_cnt), 128'd0);
      check("to.state", 128'(bus.state), 128'd0);
      tick();
      check("to.pulse_end", 128'(bus.timeout), 128'd0);
      ma = rand_msg();
      send_msg(ma, 1'b0);
      check("to.next_msg", bus.data, ma);
      check("to.next_valid", 128'(bus.msg_valid), 128'd1);
      ack_once();

      // Byte on the timeout edge wins, then byte 7 carries a framing error.
      for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b0);
      idle(TO - 1);
      send_byte(8'hA5, 1'b0, 1'b0);
      check("tov.no_timeout", 128'(bus.timeout), 128'd0);
      check("tov.cnt", 128'(bus.byte_cnt), 128'd6);
      send_byte(8'hA6, 1'b1, 1'b0);
      check("fe.pulse", 128'(bus.frame_err), 128'd1);
      check("fe.cnt", 128'(bus.byte_cnt), 128'd0);
      check("fe.no_valid", 128'(bus.msg_valid), 128'd0);
      ma = rand_msg();
      send_msg(ma, 1'b0);
      check("fe.next_msg", bus.data, ma);
      ack_once();

      // Overrun, then simultaneous ack after a reset.
      ma = rand_msg();
      mb = rand_msg();
      send_msg(ma, 1'b0);
      send_msg(mb, 1'b0);
      check("ovr.data_kept", bus.data, ma);
      check("ovr.flag", 128'(bus.overrun), 128'd1);
      check("ovr.valid", 128'(bus.msg_valid), 128'd1);
      #2 reset = 1'b1; model_reset();
      #2 reset = 1'b0;
      send_msg(ma, 1'b0);
      send_msg(mb, 1'b1);
      check("sack.data", bus.data, mb);
      check("sack.valid", 128'(bus.msg_valid), 128'd1);
      check("sack.overrun", 128'(bus.overrun), 128'd0);
      ack_once();

      // Reset asserted between edges mid-message.
      for (int i = 0; i < 9; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
      #2 reset = 1'b1; model_reset();
      #1 check_all_zero("rstmid");
      @(posedge clk);
      #2 reset = 1'b0;
      ma = rand_msg();
      for (int i = 0; i < 16; i++) begin
         send_byte(ma[127-8*i -: 8], 1'b0, 1'b0);
         check("rstmid.cnt", 128'(bus.byte_cnt), 128'((i + 1) % 16));
      end
      check("rstmid.data", bus.data, ma);
      check("rstmid.valid", 128'(bus.msg_valid), 128'd1);

      // Random traffic with occasional long silences and a reset in the middle.
      quiet = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            #2 reset = 1'b1; model_reset();
            #2 reset = 1'b0;
         end
         if (quiet > 0) begin
            quiet--;
            bus.rx_valid = 1'b0;
         end else begin
            if ($urandom_range(0, 99) < 2) quiet = $urandom_range(40, 60);
            bus.rx_valid = ($urandom_range(0, 99) < 60);
         end
         bus.rx_data = 8'($urandom());
         bus.rx_ferr = bus.rx_valid && ($urandom_range(0, 49) == 0);
         bus.msg_ack = ($urandom_range(0, 5) == 0);
         tick();
      end
      bus.rx_valid = 1'b0; bus.rx_ferr = 1'b0; bus.msg_ack = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
